ccip_mmio_avmm_requestor: RTL
=============================

// Module: ccip_mmio_avmm_requestor
// PURPOSE
// Host-to-AFU MMIO path: accepts CCI-P MMIO read/write requests from c0rx, buffers them,
// and replays them in arrival order as Avalon-MM master commands into the AFU CSR fabric.
// Read data returns on c2tx as MMIO read responses tagged with the original tid.
// Sits alongside avmm_ccip_host (AFU-to-host direction); together they form the full CCI-P bridge.
// PARAMETERS
// AVMM_ADDR_WIDTH   18  Avalon byte address width (16-bit DWORD MMIO address << 2)
// REQ_FIFO_DEPTH    64  request FIFO entries (power of 2)
// RD_TAG_DEPTH      64  outstanding-read tag FIFO entries (power of 2; CCI-P max is 64)
// PORTS
// clk                 in   1      clock
// reset               in   1      synchronous active-high reset
// c0rx                in   t_if_ccip_c0_Rx  MMIO requests (mmioRdValid/mmioWrValid, hdr, data)
// c2tx                out  t_if_ccip_c2_Tx  MMIO read response (mmioRdValid, hdr.tid, data[63:0])
// avmm_address        out  AVMM_ADDR_WIDTH  byte address, 8-byte aligned
// avmm_read           out  1      read command
// avmm_write          out  1      write command
// avmm_writedata      out  64     write data
// avmm_byteenable     out  8      byte enables
// avmm_waitrequest    in   1      slave stall
// avmm_readdata       in   64     read data
// avmm_readdatavalid  in   1      read data valid
// err_sticky          out  3      [0] req FIFO overflow, [1] 64B MMIO write, [2] spurious readdatavalid
// BEHAVIOUR
// Reset: avmm_read/write=0, c2tx.mmioRdValid=0, c2tx.hdr/data=0, FIFOs empty, err_sticky=0.
//  Reset mid-operation discards all queued requests and outstanding tags; no late responses.
// Capture: c0rx registered once (stage S1); mmioRd/mmioWr are mutually exclusive per cycle.
//  Entry = {is_wr, dw_addr[15:0], len[1:0], tid[8:0], data[63:0]} pushed from S1.
//  len=64B write: dropped, err_sticky[1] set. 64B reads are not issued by the host; no handling.
//  FIFO full at push: request dropped, err_sticky[0] set (no push even with same-cycle pop).
// Issue: FIFO head drives Avalon when non-empty; avmm_address = {dw_addr[15:1],3'b000}.
//  4B write: byteenable = dw_addr[0] ? 8'hF0 : 8'h0F; writedata = {data[31:0],data[31:0]}.
//  8B write: byteenable = 8'hFF, writedata = data. Reads: byteenable = 8'hFF.
//  Command held stable until ~avmm_waitrequest; head pops in that cycle, next head next cycle.
//  Read head additionally stalls (read deasserted) while tag FIFO full; writes behind it wait.
//  Strict arrival order; no read/write reordering.
// Latency: request on c0rx in cycle N -> avmm command visible N+2 (empty FIFO, no stall).
// Tag FIFO: on read accept push {tid, dw_addr[0], len}. On avmm_readdatavalid pop head.
//  readdatavalid with tag FIFO empty: ignored, err_sticky[2] set.
// Response: registered; c2tx.mmioRdValid pulses 1 cycle after readdatavalid, hdr.tid = tag tid.
//  8B: data = readdata. 4B: data = dw_sel ? {rd[63:32],rd[63:32]} : {rd[31:0],rd[31:0]}.
//  One response per readdatavalid; back-to-back readdatavalid gives back-to-back responses.
// FIFOs: simultaneous push+pop legal when not full; pointers wrap modulo depth.
// err_sticky bits set-only, cleared only by reset.
// TESTING
// 8B write dw_addr=0x0010 data=0x1122334455667788 -> avmm_write addr=0x40, be=FF, wdata equal, N+2.
// 4B write dw_addr=0x0013 data=0xDEADBEEF -> addr=0x48, be=F0, wdata=0xDEADBEEF_DEADBEEF.
// 4B read dw_addr=0x0005 tid=0x1A3, readdata=0xAAAA5555_12345678 -> c2tx tid=0x1A3 data=0xAAAA5555_AAAA5555.
// Mixed W,R,W,R with waitrequest high 5 cycles -> Avalon order W,R,W,R; responses tids in order.
// 65 reads, slave never returns data -> 64 issued, 65th held; one readdatavalid -> 65th issued.
// 64B write -> no Avalon traffic, err_sticky=3'b010; readdatavalid with no tags -> err_sticky[2]=1.

Source files
------------

// File: rtl/ccip_mmio_avmm_requestor.sv
`default_nettype none
// ============================================================================
// Module      : ccip_mmio_avmm_requestor (+ ccip_mmio_avmm_pkg)
// Description : Host-to-AFU MMIO path. CCI-P MMIO read/write requests from
//               c0rx are registered, buffered in an arrival-order FIFO and
//               replayed as Avalon-MM master commands. Read data returns on
//               c2tx as MMIO read responses tagged with the original tid.
// Ports       : clk, reset (sync, active high)
//               c0rx               - MMIO requests (rd/wr valid, hdr, data)
//               c2tx               - MMIO read response (valid, tid, data)
//               avmm_*             - Avalon-MM master (8-byte aligned)
//               err_sticky[2:0]    - [0] req FIFO overflow, [1] 64B MMIO
//                                    write, [2] spurious readdatavalid
// Revision    : 1.0 - initial release
// ============================================================================
package ccip_mmio_avmm_pkg;
   localparam logic [1:0] C_LEN_4B  = 2'b00;
   localparam logic [1:0] C_LEN_8B  = 2'b01;
   localparam logic [1:0] C_LEN_64B = 2'b10;

   typedef struct packed {
      logic [15:0] address;   // DWORD address
      logic [1:0]  length;
      logic [8:0]  tid;
   } t_ccip_c0_mmio_hdr;

   typedef struct packed {
      logic              mmioRdValid;
      logic              mmioWrValid;
      t_ccip_c0_mmio_hdr hdr;
      logic [63:0]       data;
   } t_if_ccip_c0_Rx;

   typedef struct packed {
      logic [8:0] tid;
   } t_ccip_c2_rsp_hdr;

   typedef struct packed {
      logic             mmioRdValid;
      t_ccip_c2_rsp_hdr hdr;
      logic [63:0]      data;
   } t_if_ccip_c2_Tx;
endpackage

module ccip_mmio_avmm_requestor
   import ccip_mmio_avmm_pkg::*;
#(
   parameter int AVMM_ADDR_WIDTH = 18,
   parameter int REQ_FIFO_DEPTH  = 64,
   parameter int RD_TAG_DEPTH    = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   input  t_if_ccip_c0_Rx             c0rx,
   output t_if_ccip_c2_Tx             c2tx,
   output logic [AVMM_ADDR_WIDTH-1:0] avmm_address,
   output logic                       avmm_read,
   output logic                       avmm_write,
   output logic [63:0]                avmm_writedata,
   output logic [7:0]                 avmm_byteenable,
   input  logic                       avmm_waitrequest,
   input  logic [63:0]                avmm_readdata,
   input  logic                       avmm_readdatavalid,
   output logic [2:0]                 err_sticky
);
   localparam int C_REQ_AW = $clog2(REQ_FIFO_DEPTH);
   localparam int C_TAG_AW = $clog2(RD_TAG_DEPTH);

   typedef struct packed {
      logic        is_wr;
      logic [15:0] dw_addr;
      logic [1:0]  len;
      logic [8:0]  tid;
      logic [63:0] data;
   } req_t;

   // Only what the response formatter needs: tid, which DWORD half, 8B or 4B.
   typedef struct packed {
      logic [8:0] tid;
      logic       dw_sel;
      logic       is_8b;
   } tag_t;

   logic              s1_valid_d, s1_valid_q;
   req_t              s1_req_d, s1_req_q;

   req_t              req_mem_q [REQ_FIFO_DEPTH];
   logic [C_REQ_AW:0] req_wptr_d, req_wptr_q, req_rptr_d, req_rptr_q;
   logic              req_empty, req_full, req_push, req_pop, req_drop;
   logic              s1_is_64b_wr;
   req_t              req_head;

   tag_t              tag_mem_q [RD_TAG_DEPTH];
   logic [C_TAG_AW:0] tag_wptr_d, tag_wptr_q, tag_rptr_d, tag_rptr_q;
   logic              tag_empty, tag_full, tag_push, tag_pop, rdv_spurious;
   tag_t              tag_head, tag_new;

   logic              rsp_valid_d, rsp_valid_q;
   logic [8:0]        rsp_tid_d, rsp_tid_q;
   logic [63:0]       rsp_data_d, rsp_data_q;
   logic [2:0]        err_d, err_q;

   always_comb begin
      // Capture stage
      s1_valid_d       = c0rx.mmioRdValid | c0rx.mmioWrValid;
      s1_req_d.is_wr   = c0rx.mmioWrValid;
      s1_req_d.dw_addr = c0rx.hdr.address;
      s1_req_d.len     = c0rx.hdr.length;
      s1_req_d.tid     = c0rx.hdr.tid;
      s1_req_d.data    = c0rx.data;

      // 64B writes are never queued; a full FIFO drops the request even if
      // the head pops in the same cycle.
      s1_is_64b_wr = s1_valid_q && s1_req_q.is_wr && (s1_req_q.len == C_LEN_64B);
      req_empty    = (req_wptr_q == req_rptr_q);
      req_full     = (req_wptr_q[C_REQ_AW] != req_rptr_q[C_REQ_AW]) &&
                     (req_wptr_q[C_REQ_AW-1:0] == req_rptr_q[C_REQ_AW-1:0]);
      req_push     = s1_valid_q && !s1_is_64b_wr && !req_full;
      req_drop     = s1_valid_q && !s1_is_64b_wr && req_full;
      req_head     = req_mem_q[req_rptr_q[C_REQ_AW-1:0]];

      tag_empty = (tag_wptr_q == tag_rptr_q);
      tag_full  = (tag_wptr_q[C_TAG_AW] != tag_rptr_q[C_TAG_AW]) &&
                  (tag_wptr_q[C_TAG_AW-1:0] == tag_rptr_q[C_TAG_AW-1:0]);
      tag_head  = tag_mem_q[tag_rptr_q[C_TAG_AW-1:0]];

      // Issue straight from the FIFO head; a read head with no free tag
      // slot stalls everything behind it to keep strict ordering.
      avmm_read    = !req_empty && !req_head.is_wr && !tag_full;
      avmm_write   = !req_empty && req_head.is_wr;
      avmm_address = AVMM_ADDR_WIDTH'({req_head.dw_addr[15:1], 3'b000});
      if (req_head.is_wr && (req_head.len == C_LEN_4B)) begin
         avmm_byteenable = req_head.dw_addr[0] ? 8'hF0 : 8'h0F;
         avmm_writedata  = {2{req_head.data[31:0]}};
      end else begin
         avmm_byteenable = 8'hFF;
         avmm_writedata  = req_head.data;
      end

      req_pop      = (avmm_read | avmm_write) && !avmm_waitrequest;
      tag_push     = avmm_read && !avmm_waitrequest;
      tag_pop      = avmm_readdatavalid && !tag_empty;
      rdv_spurious = avmm_readdatavalid && tag_empty;

      tag_new.tid    = req_head.tid;
      tag_new.dw_sel = req_head.dw_addr[0];
      tag_new.is_8b  = (req_head.len == C_LEN_8B);

      req_wptr_d = req_wptr_q + (C_REQ_AW+1)'(req_push);
      req_rptr_d = req_rptr_q + (C_REQ_AW+1)'(req_pop);
      tag_wptr_d = tag_wptr_q + (C_TAG_AW+1)'(tag_push);
      tag_rptr_d = tag_rptr_q + (C_TAG_AW+1)'(tag_pop);

      // Response formatting; hdr/data hold between responses.
      rsp_valid_d = tag_pop;
      rsp_tid_d   = rsp_tid_q;
      rsp_data_d  = rsp_data_q;
      if (tag_pop) begin
         rsp_tid_d = tag_head.tid;
         if (tag_head.is_8b)
            rsp_data_d = avmm_readdata;
         else if (tag_head.dw_sel)
            rsp_data_d = {2{avmm_readdata[63:32]}};
         else
            rsp_data_d = {2{avmm_readdata[31:0]}};
      end

      err_d = err_q | {rdv_spurious, s1_is_64b_wr, req_drop};

      c2tx.mmioRdValid = rsp_valid_q;
      c2tx.hdr.tid     = rsp_tid_q;
      c2tx.data        = rsp_data_q;
      err_sticky       = err_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q  <= 1'b0;
         s1_req_q    <= '0;
         req_wptr_q  <= '0;
         req_rptr_q  <= '0;
         tag_wptr_q  <= '0;
         tag_rptr_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_tid_q   <= '0;
         rsp_data_q  <= '0;
         err_q       <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_req_q    <= s1_req_d;
         req_wptr_q  <= req_wptr_d;
         req_rptr_q  <= req_rptr_d;
         tag_wptr_q  <= tag_wptr_d;
         tag_rptr_q  <= tag_rptr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_tid_q   <= rsp_tid_d;
         rsp_data_q  <= rsp_data_d;
         err_q       <= err_d;
      end
   end

   // Storage arrays need no reset: the pointers define validity.
   always_ff @(posedge clk) begin
      if (req_push)
         req_mem_q[req_wptr_q[C_REQ_AW-1:0]] <= s1_req_q;
      if (tag_push)
         tag_mem_q[tag_wptr_q[C_TAG_AW-1:0]] <= tag_new;
   end
endmodule
`default_nettype wire
